// File: rtl/hi_iso14443a_demod.sv
// rtl/hi_iso14443a_demod.sv - ISO14443-A envelope demodulator with slot packing and report FIFO
//
// Purpose: per adc_clk sample runs a hysteresis slicer, a deep-modulation
// detector and a windowed-average subcarrier edge detector, packs NSLOT
// {hyst,curbit} slots per report word and queues the words in a small
// show-ahead FIFO drained through a valid/ready port.
//
// Ports:
//   adc_clk    in   sample clock, all flops on rising edge
//   rst_n      in   asynchronous active-low reset
//   adc_d      in   8-bit ADC sample
//   enable     in   0 = synchronous clear of all state
//   out_data   out  FIFO head: [2N-1:N] hyst slots, [N-1:0] curbit slots, oldest at MSB
//   out_valid  out  FIFO not empty
//   out_ready  in   pop when out_valid & out_ready
//   overflow   out  sticky, a word was dropped on a full FIFO
//   after_hyst out  hysteresis slicer output
//   deep_mod   out  deep modulation present
//   dbg        out  MSB of the window sample counter
module hi_iso14443a_demod #(
  parameter int NSLOT        = 4,
  parameter int LOG2_WIN     = 4,
  parameter int HI_TH        = 192,
  parameter int LO_TH        = 16,
  parameter int HYST_TIMEOUT = 4096,
  parameter int DEEP_RUN     = 8,
  parameter int DEEP_HOLD    = 256,
  parameter int STEP_MIN     = 16,
  parameter int STEP_RESET   = 24,
  parameter int ONES_MAX     = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               adc_clk,
  input  logic               rst_n,
  input  logic [7:0]         adc_d,
  input  logic               enable,
  output logic [2*NSLOT-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow,
  output logic               after_hyst,
  output logic               deep_mod,
  output logic               dbg
);

  localparam int W     = 2 * NSLOT;
  localparam int CNTW  = LOG2_WIN + $clog2(NSLOT);
  localparam int SUMW  = 8 + LOG2_WIN;
  localparam int LOWW  = $clog2(HYST_TIMEOUT);
  localparam int ZRW   = $clog2(DEEP_RUN + 1);
  localparam int HOLDW = $clog2(DEEP_HOLD + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [7:0]       HI_B       = 8'(HI_TH);
  localparam logic [7:0]       LO_B       = 8'(LO_TH);
  localparam logic [LOWW-1:0]  LOW_LAST   = LOWW'(HYST_TIMEOUT - 1);
  localparam logic [ZRW-1:0]   ZR_MAX     = ZRW'(DEEP_RUN);
  localparam logic [ZRW-1:0]   ZR_LAST    = ZRW'(DEEP_RUN - 1);
  localparam logic [HOLDW-1:0] HOLD_MAX   = HOLDW'(DEEP_HOLD);
  localparam logic [HOLDW-1:0] HOLD_LAST  = HOLDW'(DEEP_HOLD - 1);
  localparam logic [8:0]       STEP_MIN_B = 9'(STEP_MIN);
  localparam logic [8:0]       STEP_RST_B = 9'(STEP_RESET);
  localparam logic [3:0]       ONES_LAST  = 4'(ONES_MAX - 1);

  logic              hyst_q,   hyst_d;
  logic [LOWW-1:0]   low_q,    low_d;
  logic              deep_q,   deep_d;
  logic [ZRW-1:0]    zr_q,     zr_d;
  logic [HOLDW-1:0]  hold_q,   hold_d;
  logic [CNTW-1:0]   cnt_q,    cnt_d;
  logic [SUMW-1:0]   sum_q,    sum_d;
  logic [7:0]        lavg_q,   lavg_d;
  logic              primed_q, primed_d;
  logic [8:0]        step_q,   step_d;
  logic              curbit_q, curbit_d;
  logic [3:0]        ones_q,   ones_d;
  logic [3:0]        zeros_q,  zeros_d;
  logic [NSLOT-1:0]  hpack_q,  hpack_d;
  logic [NSLOT-1:0]  cpack_q,  cpack_d;
  logic [PW:0]       rd_q,     rd_d;
  logic [PW:0]       wr_q,     wr_d;
  logic              ovf_q,    ovf_d;
  logic              valid_q,  valid_d;
  logic [W-1:0]      data_q,   head_d;
  logic [W-1:0]      mem_q [FIFO_DEPTH];

  logic              win_start, win_end, slot_end;
  logic [SUMW-1:0]   sum_acc;
  logic [7:0]        avg;
  logic [9:0]        dif;
  logic [8:0]        absdif, step_eff;
  logic              big, pop, full;
  logic              cur_new, wr_en;
  logic [W-1:0]      word;

  assign win_start = ~|cnt_q[LOG2_WIN-1:0];
  assign win_end   = &cnt_q[LOG2_WIN-1:0];
  assign slot_end  = &cnt_q;
  // The average includes the sample arriving on the window's last clock.
  assign sum_acc   = win_start ? {{LOG2_WIN{1'b0}}, adc_d}
                               : sum_q + {{LOG2_WIN{1'b0}}, adc_d};
  assign avg       = sum_acc[SUMW-1:LOG2_WIN];
  assign dif       = {2'b00, lavg_q} - {2'b00, avg};
  assign absdif    = dif[9] ? (~dif[8:0] + 9'd1) : dif[8:0];
  assign step_eff  = (step_q < STEP_MIN_B) ? STEP_MIN_B : step_q;
  // 3*|dif| > 2*step, widened so neither side can wrap.
  assign big       = ({2'b00, absdif} + {1'b0, absdif, 1'b0}) > {1'b0, step_eff, 1'b0};
  assign pop       = valid_q & out_ready;
  assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

  always_comb begin
    hyst_d   = hyst_q;
    low_d    = low_q;
    deep_d   = deep_q;
    zr_d     = zr_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q + CNTW'(1);
    sum_d    = sum_acc;
    lavg_d   = lavg_q;
    primed_d = primed_q;
    step_d   = step_q;
    curbit_d = curbit_q;
    ones_d   = ones_q;
    zeros_d  = zeros_q;
    hpack_d  = hpack_q;
    cpack_d  = cpack_q;
    ovf_d    = ovf_q;
    cur_new  = curbit_q;
    wr_en    = 1'b0;
    head_d   = '0;

    // Slicer; the low-run timeout takes priority over the thresholds.
    if (hyst_q) begin
      low_d = '0;
      if (adc_d < LO_B) hyst_d = 1'b0;
    end else if (low_q == LOW_LAST) begin
      hyst_d = 1'b1;
      low_d  = '0;
    end else begin
      low_d = low_q + LOWW'(1);
      if (adc_d >= HI_B) hyst_d = 1'b1;
    end

    // Deep modulation: both run counters saturate so long runs keep their state.
    if (adc_d == 8'd0) begin
      hold_d = '0;
      if (zr_q != ZR_MAX) zr_d = zr_q + ZRW'(1);
      if (zr_q >= ZR_LAST) deep_d = 1'b1;
    end else begin
      zr_d = '0;
      if (hold_q != HOLD_MAX) hold_d = hold_q + HOLDW'(1);
      if (hold_q >= HOLD_LAST) deep_d = 1'b0;
    end

    if (win_end) begin
      lavg_d   = avg;
      primed_d = 1'b1;
      // The first window after a clear only establishes the reference average.
      if (primed_q) begin
        step_d = step_eff;
        if (big) begin
          cur_new = dif[9];
          step_d  = absdif;
        end
        if (cur_new) begin
          zeros_d = '0;
          if (ones_q == ONES_LAST) begin
            cur_new = 1'b0;
            step_d  = STEP_RST_B;
            ones_d  = '0;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          ones_d = '0;
          if (zeros_q != 4'd15) zeros_d = zeros_q + 4'd1;
          if (zeros_q >= 4'd14) step_d = STEP_RST_B;
        end
        curbit_d = cur_new;
      end
      hpack_d = (hpack_q << 1) | NSLOT'(hyst_q);
      cpack_d = (cpack_q << 1) | NSLOT'(cur_new);
    end

    word = {hpack_d, cpack_d & {NSLOT{~deep_q}}};

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en = slot_end & (~full | pop);
    if (slot_end & full & ~pop) ovf_d = 1'b1;
    rd_d    = rd_q + {{PW{1'b0}}, pop};
    wr_d    = wr_q + {{PW{1'b0}}, wr_en};
    valid_d = (rd_d != wr_d);
    if (!valid_d)
      head_d = '0;
    else if (wr_en && (wr_q[PW-1:0] == rd_d[PW-1:0]))
      head_d = word;
    else
      head_d = mem_q[rd_d[PW-1:0]];

    if (!enable) begin
      hyst_d   = 1'b0;
      low_d    = '0;
      deep_d   = 1'b0;
      zr_d     = '0;
      hold_d   = '0;
      cnt_d    = '0;
      sum_d    = '0;
      lavg_d   = '0;
      primed_d = 1'b0;
      step_d   = STEP_MIN_B;
      curbit_d = 1'b0;
      ones_d   = '0;
      zeros_d  = '0;
      hpack_d  = '0;
      cpack_d  = '0;
      rd_d     = '0;
      wr_d     = '0;
      ovf_d    = 1'b0;
      valid_d  = 1'b0;
      head_d   = '0;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      hyst_q   <= 1'b0;
      low_q    <= '0;
      deep_q   <= 1'b0;
      zr_q     <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      lavg_q   <= '0;
      primed_q <= 1'b0;
      step_q   <= STEP_MIN_B;
      curbit_q <= 1'b0;
      ones_q   <= '0;
      zeros_q  <= '0;
      hpack_q  <= '0;
      cpack_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      hyst_q   <= hyst_d;
      low_q    <= low_d;
      deep_q   <= deep_d;
      zr_q     <= zr_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      lavg_q   <= lavg_d;
      primed_q <= primed_d;
      step_q   <= step_d;
      curbit_q <= curbit_d;
      ones_q   <= ones_d;
      zeros_q  <= zeros_d;
      hpack_q  <= hpack_d;
      cpack_q  <= cpack_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      data_q   <= head_d;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (wr_en) mem_q[wr_q[PW-1:0]] <= word;
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign overflow   = ovf_q;
  assign after_hyst = hyst_q;
  assign deep_mod   = deep_q;
  assign dbg        = cnt_q[CNTW-1];

endmodule

// File: tb/tb_hi_iso14443a_demod.sv
// tb/tb_hi_iso14443a_demod.sv - randomized bench for hi_iso14443a_demod against a behavioural model
module tb_hi_iso14443a_demod;

  logic       adc_clk = 1'b0;
  logic       rst_n;
  logic [7:0] adc_d;
  logic       enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       after_hyst;
  logic       deep_mod;
  logic       dbg;

  hi_iso14443a_demod dut (
    .adc_clk    (adc_clk),
    .rst_n      (rst_n),
    .adc_d      (adc_d),
    .enable     (enable),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .after_hyst (after_hyst),
    .deep_mod   (deep_mod),
    .dbg        (dbg)
  );

  always #5 adc_clk = ~adc_clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: plain integers, queues for the FIFO.
  int m_hyst, m_low, m_deep, m_zr, m_hold;
  int m_n, m_sum, m_lavg, m_primed, m_step, m_cb, m_ones, m_zeros;
  int m_hw, m_cw, m_ovf;
  logic [7:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hyst = 0; m_low = 0; m_deep = 0; m_zr = 0; m_hold = 0;
    m_n = 0; m_sum = 0; m_lavg = 0; m_primed = 0; m_step = 16; m_cb = 0;
    m_ones = 0; m_zeros = 0; m_hw = 0; m_cw = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_tick(input int d, input bit en, input bit rdy);
    int  old_h, old_dp, avg, dif, mag, w;
    bit  pop, push;
    if (!en) begin
      model_clear();
    end else begin
      old_h  = m_hyst;
      old_dp = m_deep;
      pop    = (m_q.size() > 0) && rdy;
      push   = 0;
      w      = 0;
      if (m_hyst != 0) begin
        m_low = 0;
        if (d < 16) m_hyst = 0;
      end else begin
        m_low++;
        if (m_low == 4096) begin m_hyst = 1; m_low = 0; end
        else if (d >= 192) m_hyst = 1;
      end
      if (d == 0) begin
        m_hold = 0; m_zr++;
        if (m_zr >= 8) m_deep = 1;
      end else begin
        m_zr = 0; m_hold++;
        if (m_hold >= 256) m_deep = 0;
      end
      m_sum += d;
      m_n++;
      if (m_n % 16 == 0) begin
        avg   = m_sum / 16;
        m_sum = 0;
        if (m_primed != 0) begin
          dif = m_lavg - avg;
          mag = (dif < 0) ? -dif : dif;
          if (m_step < 16) m_step = 16;
          if (3 * mag > 2 * m_step) begin
            m_cb   = (dif < 0) ? 1 : 0;
            m_step = mag;
          end
          if (m_cb != 0) begin
            m_zeros = 0;
            m_ones++;
            if (m_ones == 12) begin m_cb = 0; m_step = 24; m_ones = 0; end
          end else begin
            m_ones = 0;
            if (m_zeros < 15) m_zeros++;
            if (m_zeros == 15) m_step = 24;
          end
        end
        m_primed = 1;
        m_lavg   = avg;
        m_hw = ((m_hw << 1) | old_h) & 15;
        m_cw = ((m_cw << 1) | m_cb) & 15;
        if (m_n % 64 == 0) begin
          push = 1;
          w    = (m_hw << 4) | ((old_dp != 0) ? 0 : m_cw);
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 4) m_q.push_back(8'(w));
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("after_hyst", after_hyst, m_hyst);
    chk("deep_mod", deep_mod, m_deep);
    chk("out_valid", out_valid, (m_q.size() > 0) ? 1 : 0);
    chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("overflow", overflow, m_ovf);
    chk("dbg", dbg, ((m_n % 64) >= 32) ? 1 : 0);
  endtask

  task automatic step(input logic [7:0] d, input logic rdy);
    adc_d     = d;
    out_ready = rdy;
    @(posedge adc_clk);
    model_tick(int'(d), enable & rst_n, rdy);
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_w [4];
    int lvl, mode, d;
    exp_w = '{8'hF1, 8'hFF, 8'hFF, 8'hFC};

    rst_n = 1'b0; enable = 1'b0; adc_d = 8'd0; out_ready = 1'b0;
    model_clear();
    #12;
    check_all();
    rst_n  = 1'b1;
    enable = 1'b1;

    // Constant carrier: F0 words, no overflow.
    repeat (256) step(8'd200, 1'b1);
    chk("const_word", out_data, 8'hF0);
    chk("const_ovf", overflow, 1'b0);

    // Level edges: 200,200,100 then 200 held; forced curbit drop on 12th one.
    enable = 1'b0;
    step(8'd200, 1'b1);
    enable = 1'b1;
    for (int w = 0; w < 16; w++) begin
      lvl = (w == 2) ? 100 : 200;
      repeat (16) step(8'(lvl), 1'b1);
      if (w % 4 == 3) chk("edge_word", out_data, exp_w[w / 4]);
    end

    // Hysteresis timeout after a drop to low state.
    step(8'd0, 1'b1);
    repeat (4095) step(8'd100, 1'b1);
    chk("hyst_pre", after_hyst, 1'b0);
    step(8'd100, 1'b1);
    chk("hyst_timeout", after_hyst, 1'b1);

    // Deep modulation assert and release.
    repeat (300) step(8'd200, 1'b1);
    repeat (7) step(8'd0, 1'b1);
    chk("deep_pre", deep_mod, 1'b0);
    step(8'd0, 1'b1);
    chk("deep_set", deep_mod, 1'b1);
    repeat (255) step(8'd150, 1'b1);
    chk("deep_hold", deep_mod, 1'b1);
    step(8'd150, 1'b1);
    chk("deep_rel", deep_mod, 1'b0);

    // FIFO fill, overflow, push+pop on full, enable clear.
    enable = 1'b0;
    step(8'd200, 1'b0);
    enable = 1'b1;
    repeat (320) step(8'd200, 1'b0);
    chk("fifo_ovf", overflow, 1'b1);
    chk("fifo_valid", out_valid, 1'b1);
    chk("fifo_head", out_data, 8'hF0);
    repeat (63) step(8'd200, 1'b0);
    step(8'd200, 1'b1);
    repeat (4) step(8'd200, 1'b1);
    enable = 1'b0;
    step(8'd200, 1'b1);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_ovf", overflow, 1'b0);
    enable = 1'b1;

    // Randomized windows: noisy levels, zero bursts, random samples, random backpressure.
    for (int w = 0; w < 250; w++) begin
      lvl  = int'($urandom_range(20, 250));
      mode = int'($urandom_range(0, 7));
      for (int s = 0; s < 16; s++) begin
        d = lvl + int'($urandom_range(0, 8)) - 4;
        if (d > 255) d = 255;
        if (mode == 0) d = 0;
        if (mode == 1) d = int'($urandom_range(0, 255));
        step(8'(d), ($urandom_range(0, 3) != 0));
      end
    end

    // Asynchronous reset in the middle of a word.
    repeat (20) step(8'd200, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_hyst", after_hyst, 1'b0);
    chk("rst_deep", deep_mod, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_dbg", dbg, 1'b0);
    model_clear();
    step(8'd200, 1'b1);
    rst_n = 1'b1;
    repeat (100) step(8'd200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
